// File: rtl/router_fsm.sv
// router_fsm: header-decode and load-sequencing FSM for a 3-port packet router.
// Optional accepted-packet counter is built only when ROUTER_FSM_PKT_STATS_EN is defined.
module router_fsm #(
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pkt_valid,
  input  logic [1:0]        data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [STAT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy
  localparam logic [7:0] OUT_RESET = 8'b1000_0000;

  state_t     state_r;
  state_t     next_s;
  logic [1:0] addr_r;
  logic       soft_hit_s;
  logic       empty_addr_s;
  logic       empty_hdr_s;
  logic [7:0] out_nxt_s;
  logic [7:0] out_r;

  function automatic logic pick_port(input logic [1:0] idx, input logic p0,
                                     input logic p1, input logic p2);
    logic res;
    case (idx)
      2'd0:    res = p0;
      2'd1:    res = p1;
      2'd2:    res = p2;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign soft_hit_s   = pick_port(addr_r,  soft_reset_0, soft_reset_1, soft_reset_2);
  assign empty_addr_s = pick_port(addr_r,  fifo_empty_0, fifo_empty_1, fifo_empty_2);
  assign empty_hdr_s  = pick_port(data_in, fifo_empty_0, fifo_empty_1, fifo_empty_2);

  // State, registered outputs (pre-decoded from next state) and latched port address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= DECODE_ADDRESS;
      out_r   <= OUT_RESET;
      addr_r  <= 2'd0;
    end else begin
      state_r <= next_s;
      out_r   <= out_nxt_s;
      if (state_r == DECODE_ADDRESS && pkt_valid && data_in != 2'd3) begin
        addr_r <= data_in;
      end
    end
  end

  // Next-state logic; a soft reset of the latched port overrides every transition
  always_comb begin
    next_s = state_r;
    if (soft_hit_s) begin
      next_s = DECODE_ADDRESS;
    end else begin
      case (state_r)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != 2'd3) begin
            if (empty_hdr_s) next_s = LOAD_FIRST_DATA;
            else             next_s = WAIT_TILL_EMPTY;
          end else begin
            next_s = DECODE_ADDRESS;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_addr_s) next_s = LOAD_FIRST_DATA;
          else              next_s = WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: next_s = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       next_s = FIFO_FULL_STATE;
          else if (!pkt_valid) next_s = LOAD_PARITY;
          else                 next_s = LOAD_DATA;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) next_s = LOAD_AFTER_FULL;
          else            next_s = FIFO_FULL_STATE;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        next_s = DECODE_ADDRESS;
          else if (low_pkt_valid) next_s = LOAD_PARITY;
          else                    next_s = LOAD_DATA;
        end
        LOAD_PARITY: next_s = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) next_s = FIFO_FULL_STATE;
          else           next_s = DECODE_ADDRESS;
        end
        default: next_s = DECODE_ADDRESS;
      endcase
    end
  end

  // Output decode of the upcoming state so the flops present the current-state decode
  always_comb begin
    out_nxt_s = OUT_RESET;
    case (next_s)
      DECODE_ADDRESS:     out_nxt_s = 8'b1000_0000;
      WAIT_TILL_EMPTY:    out_nxt_s = 8'b0000_0001;
      LOAD_FIRST_DATA:    out_nxt_s = 8'b0100_0001;
      LOAD_DATA:          out_nxt_s = 8'b0010_0100;
      FIFO_FULL_STATE:    out_nxt_s = 8'b0000_1001;
      LOAD_AFTER_FULL:    out_nxt_s = 8'b0001_0101;
      LOAD_PARITY:        out_nxt_s = 8'b0000_0101;
      CHECK_PARITY_ERROR: out_nxt_s = 8'b0000_0011;
      default:            out_nxt_s = OUT_RESET;
    endcase
  end

  assign {detect_add, lfd_state, ld_state, laf_state,
          full_state, write_enb_reg, rst_int_reg, busy} = out_r;

`ifdef ROUTER_FSM_PKT_STATS_EN
  logic [STAT_W-1:0] pkt_count_r;

  // Count packets as they leave LOAD_FIRST_DATA into LOAD_DATA; wraps naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_count_r <= {STAT_W{1'b0}};
    end else if (state_r == LOAD_FIRST_DATA && next_s == LOAD_DATA) begin
      pkt_count_r <= pkt_count_r + STAT_W'(1);
    end
  end

  assign pkt_count = pkt_count_r;
`else
  assign pkt_count = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed vector table, corner sequences,
// and randomized traffic against a state-level reference model.
module tb_router_fsm;

  localparam int STAT_W = 8;

  localparam logic [7:0] O_IDLE  = 8'b1000_0000;
  localparam logic [7:0] O_WAIT  = 8'b0000_0001;
  localparam logic [7:0] O_FIRST = 8'b0100_0001;
  localparam logic [7:0] O_BODY  = 8'b0010_0100;
  localparam logic [7:0] O_FULL  = 8'b0000_1001;
  localparam logic [7:0] O_AFTER = 8'b0001_0101;
  localparam logic [7:0] O_PAR   = 8'b0000_0101;
  localparam logic [7:0] O_CHK   = 8'b0000_0011;

  logic              clk = 1'b0;
  logic              rstn;
  logic              pkt_valid;
  logic [1:0]        data_in;
  logic              fifo_full;
  logic [2:0]        empt;
  logic [2:0]        srst;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              detect_add, lfd_state, ld_state, laf_state;
  logic              full_state, write_enb_reg, rst_int_reg, busy;
  logic [STAT_W-1:0] pkt_count;
  logic [7:0]        outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  router_fsm #(.STAT_W(STAT_W)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(empt[0]), .fifo_empty_1(empt[1]), .fifo_empty_2(empt[2]),
    .soft_reset_0(srst[0]), .soft_reset_1(srst[1]), .soft_reset_2(srst[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .pkt_count(pkt_count)
  );

  assign outs = {detect_add, lfd_state, ld_state, laf_state,
                 full_state, write_enb_reg, rst_int_reg, busy};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic full,
                       input logic [2:0] e, input logic [2:0] s,
                       input logic pd, input logic lpv);
    pkt_valid = pv; data_in = din; fifo_full = full; empt = e; srst = s;
    parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic edge_chk(input string name, input logic [7:0] exp);
    @(posedge clk); #1;
    chk(name, {24'd0, outs}, {24'd0, exp});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] e;
    logic       pd;
    logic       lpv;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[20];

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_FIRST, M_BODY, M_FULL, M_AFTER, M_PAR, M_CHK} mst_t;
  mst_t m_state;
  int   m_addr;
  int   m_cnt;

  function automatic logic [7:0] exp_of(input mst_t st);
    case (st)
      M_IDLE:  return O_IDLE;
      M_WAIT:  return O_WAIT;
      M_FIRST: return O_FIRST;
      M_BODY:  return O_BODY;
      M_FULL:  return O_FULL;
      M_AFTER: return O_AFTER;
      M_PAR:   return O_PAR;
      M_CHK:   return O_CHK;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_addr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    mst_t nx;
    nx = m_state;
    case (m_state)
      M_IDLE:  if (pkt_valid && data_in != 2'd3) nx = empt[data_in] ? M_FIRST : M_WAIT;
      M_WAIT:  if (empt[m_addr]) nx = M_FIRST;
      M_FIRST: nx = M_BODY;
      M_BODY:  if (fifo_full) nx = M_FULL; else if (!pkt_valid) nx = M_PAR;
      M_FULL:  if (!fifo_full) nx = M_AFTER;
      M_AFTER: nx = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_BODY);
      M_PAR:   nx = M_CHK;
      M_CHK:   nx = fifo_full ? M_FULL : M_IDLE;
      default: nx = M_IDLE;
    endcase
    if (srst[m_addr]) nx = M_IDLE;
`ifdef ROUTER_FSM_PKT_STATS_EN
    if (m_state == M_FIRST && nx == M_BODY) m_cnt = (m_cnt + 1) % (1 << STAT_W);
`endif
    if (m_state == M_IDLE && pkt_valid && data_in != 2'd3) m_addr = int'(data_in);
    m_state = nx;
  endtask

  function automatic int exp_cnt(input int packets);
`ifdef ROUTER_FSM_PKT_STATS_EN
    return packets % (1 << STAT_W);
`else
    return 0;
`endif
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    // normal packet to port 1 with 4 payload cycles
    tbl[0]  = '{1'b1, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_FIRST};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_BODY};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_BODY};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_BODY};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_BODY};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_PAR};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_CHK};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0, O_IDLE};
    // full handling on port 0
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, O_FIRST};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, O_BODY};
    tbl[10] = '{1'b1, 2'd0, 1'b1, 3'b111, 1'b0, 1'b0, O_FULL};
    tbl[11] = '{1'b1, 2'd0, 1'b1, 3'b111, 1'b0, 1'b0, O_FULL};
    tbl[12] = '{1'b1, 2'd0, 1'b1, 3'b111, 1'b0, 1'b0, O_FULL};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, O_AFTER};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 3'b111, 1'b0, 1'b1, O_PAR};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, O_CHK};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 3'b111, 1'b0, 1'b0, O_FULL};
    tbl[17] = '{1'b0, 2'd0, 1'b0, 3'b111, 1'b0, 1'b0, O_AFTER};
    tbl[18] = '{1'b0, 2'd0, 1'b0, 3'b111, 1'b1, 1'b1, O_IDLE};
    // invalid header address keeps the FSM in decode
    tbl[19] = '{1'b1, 2'd3, 1'b0, 3'b111, 1'b0, 1'b0, O_IDLE};

    // reset state
    rstn = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    #12;
    chk("reset_outs", {24'd0, outs}, {24'd0, O_IDLE});
    chk("reset_cnt", {24'd0, pkt_count}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].pv, tbl[i].din, tbl[i].full, tbl[i].e, 3'b000, tbl[i].pd, tbl[i].lpv);
      edge_chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // busy target: port 2 not empty for 5 cycles
    drive(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      edge_chk($sformatf("wait%0d", i), O_WAIT);
      pkt_valid = 1'b0;
    end
    empt = 3'b111;
    edge_chk("wait_exit", O_FIRST);
    pkt_valid = 1'b0;
    edge_chk("wait_ld", O_BODY);
    edge_chk("wait_par", O_PAR);
    edge_chk("wait_chk", O_CHK);
    edge_chk("wait_idle", O_IDLE);

    // soft reset: only the latched port's soft reset applies
    drive(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
    edge_chk("sr_wait", O_WAIT);
    srst = 3'b010;
    edge_chk("sr_other", O_WAIT);
    srst = 3'b001;
    edge_chk("sr_own", O_IDLE);
    srst = 3'b000;

    // async reset in the middle of LOAD_DATA
    drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    edge_chk("ar_lfd", O_FIRST);
    edge_chk("ar_ld", O_BODY);
    #2 rstn = 1'b0;
    #1;
    chk("ar_same_cycle", {24'd0, outs}, {24'd0, O_IDLE});
    #1 rstn = 1'b1;
    pkt_valid = 1'b0;
    edge_chk("ar_after", O_IDLE);
    pkt_valid = 1'b1;
    edge_chk("ar_restart", O_FIRST);

    // packet statistics with wrap
    do_reset();
    for (int p = 1; p <= 257; p++) begin
      drive(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      @(posedge clk); #1;
      pkt_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      if (p == 1 || p == 256 || p == 257)
        chk($sformatf("cnt_p%0d", p), {24'd0, pkt_count}, exp_cnt(p));
    end
    drive(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    edge_chk("cnt_bad_hdr_state", O_IDLE);
    chk("cnt_bad_hdr", {24'd0, pkt_count}, exp_cnt(257));

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      empt          = 3'($urandom_range(0, 7));
      srst          = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 15) == 0)};
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = 1'($urandom_range(0, 1));
      rstn          = ($urandom_range(0, 149) != 0);
      if (!rstn) begin
        model_reset();
        #1;
        chk("rnd_async", {24'd0, outs}, {24'd0, exp_of(m_state)});
      end else begin
        model_step();
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d", c), {24'd0, outs}, {24'd0, exp_of(m_state)});
      chk($sformatf("rnd_cnt%0d", c), {24'd0, pkt_count}, m_cnt);
    end
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have parameter STAT_W, default 8, width of packet counter pkt_count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pkt_valid  input  1  source packet-in-progress qualifier.
REQ-005 SHALL have port data_in  input  2  header address bits: 0/1/2 = port 0/1/2, 3 = invalid.
REQ-006 SHALL have port fifo_full  input  1  full flag of currently addressed FIFO.
REQ-007 SHALL have ports fifo_empty_0/1/2  input  1 each  per-port FIFO empty flags.
REQ-008 SHALL have ports soft_reset_0/1/2  input  1 each  per-port read-timeout soft resets.
REQ-009 SHALL have ports parity_done, low_pkt_valid  input  1 each  register-block status.
REQ-010 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy  output  1 each  state decodes.
REQ-011 SHALL have port pkt_count  output  STAT_W  accepted-packet count.

Function
REQ-012 SHALL implement a registered Moore FSM: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR.
REQ-013 SHALL latch data_in into internal addr when in DECODE_ADDRESS with pkt_valid=1 and data_in!=3.
REQ-014 DECODE_ADDRESS: pkt_valid, data_in=n (n<3), fifo_empty_n=1 -> LOAD_FIRST_DATA; same with fifo_empty_n=0 -> WAIT_TILL_EMPTY; otherwise (incl. data_in=3) stay.
REQ-015 WAIT_TILL_EMPTY: fifo_empty of latched addr =1 -> LOAD_FIRST_DATA; else stay.
REQ-016 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
REQ-017 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay; fifo_full takes priority.
REQ-018 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-019 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else LOAD_DATA.
REQ-020 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-021 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-022 soft_reset_n asserted with latched addr=n SHALL force DECODE_ADDRESS next edge from any state, overriding REQ-014..021; soft_reset for other ports ignored.
REQ-023 Outputs SHALL be decoded from current state only: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-024 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; 0 elsewhere.
REQ-025 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA; 1 in all other states.
REQ-026 Latency: state change visible on outputs one clk after qualifying inputs sampled.

Reset
REQ-027 rstn=0 SHALL asynchronously force DECODE_ADDRESS, addr=0, pkt_count=0; outputs: detect_add=1, all other 1-bit outputs 0.
REQ-028 Reset mid-packet SHALL abandon packet; no residual state.
REQ-029 Release SHALL be sampled on next rising clk; first transition possible on that edge.

Configuration
REQ-030 Macro ROUTER_FSM_PKT_STATS_EN defined: pkt_count SHALL increment by 1 on each LOAD_FIRST_DATA->LOAD_DATA transition, wrapping 2^STAT_W-1 -> 0, held on soft reset.
REQ-031 Macro undefined: pkt_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-032 Reset: rstn=0 mid LOAD_DATA -> same-cycle detect_add=1, write_enb_reg=0, busy=0.
REQ-033 Normal pkt: pkt_valid=1, data_in=1, fifo_empty_1=1, 4 payload cycles, pkt_valid=0 -> lfd 1 cycle, ld 4 cycles, LOAD_PARITY 1 cycle, rst_int_reg 1 cycle, back to detect_add=1.
REQ-034 Busy target: data_in=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY busy=1 5 cycles, then lfd_state=1.
REQ-035 Full: fifo_full=1 in LOAD_DATA 3 cycles -> full_state=1 3 cycles, then laf_state=1; low_pkt_valid=1 -> LOAD_PARITY next.
REQ-036 Soft reset: in WAIT_TILL_EMPTY addr=0, soft_reset_0=1 -> DECODE_ADDRESS next edge; soft_reset_1=1 instead -> no change.
REQ-037 Stats (macro on, STAT_W=8): 257 packets -> pkt_count=1; data_in=3 header -> no change, FSM stays DECODE_ADDRESS.
